state_sequencer: RTL and testbench
==================================

STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 SHALL have parameter N, default 1, meaning qubit count; the vector holds 2**N complex elements.
REQ-002 SHALL have parameter MULT_LAT, default 1, legal range 1..15, meaning settle cycles allowed for the downstream gate-state multiplier.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port gate_valid, input, 1 bit: a gate element is offered.
REQ-006 SHALL have port gate_elem, input, 16 bits: one complex element; [15:8] is real part a, [7:0] is imaginary part b; each byte is 8-bit sign-magnitude with 6 fractional bits.
REQ-007 SHALL have port gate_ready, output, 1 bit: gate_elem is accepted on a clock edge where gate_valid and gate_ready are both high.
REQ-008 SHALL have port init, input, 1 bit: request to reinitialise the state to |0>.
REQ-009 SHALL have port gate_out, output, 16*4**N bits: the assembled gate matrix; element r*2**N+c occupies [16k+15:16k] with k = r*2**N+c.
REQ-010 SHALL have port state_out, output, 16*2**N bits: the current state vector; element k occupies [16k+15:16k].
REQ-011 SHALL have port mult_state, input, 16*2**N bits: the multiplier result (gate_out x state_out), packed the same way as state_out.
REQ-012 SHALL have port busy, output, 1 bit: high in SETTLE and COMMIT.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a gate is committed.

Function
REQ-014 SHALL implement the FSM states LOAD, SETTLE and COMMIT.
REQ-015 In LOAD: gate_ready = !init; each accepted element is written to matrix slot idx and idx increments; elements arrive in row-major order.
REQ-016 Accepting element 4**N-1 SHALL reset idx to 0, load the SETTLE counter with MULT_LAT, and move to SETTLE on that same edge.
REQ-017 In SETTLE: the counter decrements every cycle; when it reaches 1, the FSM moves to COMMIT (SETTLE lasts exactly MULT_LAT cycles).
REQ-018 In COMMIT: done=1 for exactly one cycle; state_out captures mult_state on the edge that ends COMMIT; the next state is LOAD.
REQ-019 Latency SHALL be fixed: a new state_out is visible MULT_LAT+1 cycles after the last-element accept edge.
REQ-020 gate_ready SHALL be 0 in SETTLE and COMMIT; gate_valid is ignored in those states.
REQ-021 gate_out and state_out SHALL be held stable throughout SETTLE and COMMIT.
REQ-022 init high in LOAD SHALL set state_out to |0> (element 0 = 0x4000, all others 0x0000), clear idx, and discard any partially loaded matrix.
REQ-023 init high in SETTLE or COMMIT SHALL be ignored.
REQ-024 init and gate_valid high together in LOAD: init wins and no element is accepted.
REQ-025 The block SHALL perform no arithmetic; mult_state is captured bit-exact with no saturation or renormalisation.

Reset
REQ-026 reset low at a clock edge, in any state including mid-load or mid-SETTLE, SHALL set:
- FSM to LOAD, idx=0, SETTLE counter=0;
- gate_out all 0, state_out = |0>;
- done=0, busy=0; gate_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-027 Macro STATE_SEQUENCER_GATE_COUNT_EN SHALL control the gate counter.
- Defined: output port gate_count (8 bits) exists; reset and init clear it to 0; it increments on each COMMIT and wraps 255->0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Verification
REQ-028 Reset: N=1, reset low for 2 cycles -> state_out=0x0000_4000, gate_ready=1, done=0, busy=0.
REQ-029 Hadamard: stream 0x2D00,0x2D00,0x2D00,0xAD00 with the multiplier model connected, MULT_LAT=1 -> done 2 cycles after the last accept; state_out=0x2D00_2D00.
REQ-030 Pauli-X: stream 0x0000,0x4000,0x4000,0x0000 from |0> -> state_out=0x4000_0000; X applied again -> 0x0000_4000; gate_count=2.
REQ-031 Backpressure and conflict: gate_valid held high through SETTLE with MULT_LAT=3 -> no extra accepts, busy high 4 cycles; init+gate_valid together in LOAD -> element not accepted, idx=0.
REQ-032 Mid-operation and wrap:
- Partial load of 2 elements, then init -> the next 4 elements form a fresh matrix.
- reset during SETTLE -> state_out=|0>, done never pulses.
- 256 commits -> gate_count=0 (macro defined).

Source files
------------

// File: rtl/state_sequencer.sv
// Loads a gate matrix element by element, waits for the external multiplier to settle, then commits its result.
// Optional 8-bit commit counter on port gate_count when STATE_SEQUENCER_GATE_COUNT_EN is defined.
module state_sequencer #(
  parameter int N        = 1,
  parameter int MULT_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gate_valid,
  input  logic [15:0]           gate_elem,
  output logic                  gate_ready,
  input  logic                  init,
  output logic [16*(4**N)-1:0]  gate_out,
  output logic [16*(2**N)-1:0]  state_out,
  input  logic [16*(2**N)-1:0]  mult_state,
  output logic                  busy,
  output logic                  done
`ifdef STATE_SEQUENCER_GATE_COUNT_EN
  ,
  output logic [7:0]            gate_count
`endif
);

  localparam int NE = 4**N;
  localparam int NS = 2**N;
  localparam int IW = 2*N;
  localparam int GW = 16*NE;
  localparam int SW = 16*NS;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(NE-1);
  localparam logic [3:0]    LAT  = 4'(MULT_LAT);
  // |0>: element 0 is +1.0 in Q1.6 sign-magnitude, all others zero
  localparam logic [SW-1:0] KET0 = SW'(16'h4000);

  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [3:0]    r_cnt;
  logic [GW-1:0] r_gate;
  logic [SW-1:0] r_vec;

  logic w_load;
  logic w_settle;
  logic w_commit;
  logic w_accept;
  logic w_last;

  assign w_load   = (r_state == S_LOAD);
  assign w_settle = (r_state == S_SETTLE);
  assign w_commit = (r_state == S_COMMIT);
  assign w_accept = w_load & gate_valid & ~init;
  assign w_last   = (r_idx == LAST);

  assign gate_ready = w_load & ~init;
  assign busy       = ~w_load;
  assign done       = w_commit;
  assign gate_out   = r_gate;
  assign state_out  = r_vec;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_LOAD;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_gate  <= '0;
      r_vec   <= KET0;
    end else begin
      unique case (1'b1)
        w_load: begin
          if (init) begin
            r_idx  <= '0;
            r_gate <= '0;
            r_vec  <= KET0;
          end else if (w_accept) begin
            r_gate[{r_idx, 4'b0000} +: 16] <= gate_elem;
            if (w_last) begin
              r_idx   <= '0;
              r_cnt   <= LAT;
              r_state <= S_SETTLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        w_settle: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_COMMIT;
          end
        end
        w_commit: begin
          r_vec   <= mult_state;
          r_state <= S_LOAD;
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

`ifdef STATE_SEQUENCER_GATE_COUNT_EN
  logic [7:0] r_gcnt;

  assign gate_count = r_gcnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_gcnt <= '0;
    end else if (w_load && init) begin
      r_gcnt <= '0;
    end else if (w_commit) begin
      r_gcnt <= r_gcnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: two instances (MULT_LAT 1 and 3) with a behavioural multiplier
// and a transaction-level reference model.
module tb_state_sequencer;

  localparam int N = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              gv   [2];
  logic [15:0]       ge   [2];
  logic              ini  [2];
  logic              rdy  [2];
  logic [63:0]       gout [2];
  logic [31:0]       sout [2];
  logic [1:0][31:0]  mst;
  logic              bsy  [2];
  logic              dn   [2];
`ifdef STATE_SEQUENCER_GATE_COUNT_EN
  logic [7:0]        gcnt [2];
`endif

  int checks = 0;
  int errs   = 0;

  int          lat       [2];
  int          busy_left [2];
  int          npend     [2];
  logic [15:0] pend      [2][4];
  logic [63:0] m_gate    [2];
  logic [31:0] m_state   [2];
  int          m_count   [2];

  function automatic int sm2i(input logic [7:0] b);
    int mag;
    mag = int'(b[6:0]);
    return b[7] ? -mag : mag;
  endfunction

  function automatic logic [7:0] i2sm(input int x);
    int a;
    a = (x < 0) ? -x : x;
    if (a > 127) a = 127;
    return {(x < 0), 7'(a)};
  endfunction

  // complex 2x2 matrix times 2-vector, Q1.6 in, truncated Q1.6 out
  function automatic logic [31:0] cmul(input logic [63:0] m,
                                       input logic [31:0] v);
    logic [31:0] r;
    int re, im, ar, ai, vr, vi;
    r = '0;
    for (int row = 0; row < 2; row++) begin
      re = 0;
      im = 0;
      for (int c = 0; c < 2; c++) begin
        ar = sm2i(m[16*(row*2+c)+8 +: 8]);
        ai = sm2i(m[16*(row*2+c) +: 8]);
        vr = sm2i(v[16*c+8 +: 8]);
        vi = sm2i(v[16*c +: 8]);
        re += ar*vr - ai*vi;
        im += ar*vi + ai*vr;
      end
      r[16*row +: 16] = {i2sm(re / 64), i2sm(im / 64)};
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    state_sequencer #(
      .N        (N),
      .MULT_LAT ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .gate_valid (gv[g]),
      .gate_elem  (ge[g]),
      .gate_ready (rdy[g]),
      .init       (ini[g]),
      .gate_out   (gout[g]),
      .state_out  (sout[g]),
      .mult_state (mst[g]),
      .busy       (bsy[g]),
      .done       (dn[g])
`ifdef STATE_SEQUENCER_GATE_COUNT_EN
      ,
      .gate_count (gcnt[g])
`endif
    );
    assign mst[g] = cmul(gout[g], sout[g]);
  end

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        busy_left[d] = 0;
        npend[d]     = 0;
        m_state[d]   = 32'h0000_4000;
        m_gate[d]    = '0;
        m_count[d]   = 0;
      end else if (busy_left[d] > 0) begin
        busy_left[d]--;
        if (busy_left[d] == 0) begin
          m_state[d] = cmul(m_gate[d], m_state[d]);
          m_count[d] = (m_count[d] + 1) % 256;
        end
      end else if (ini[d]) begin
        npend[d]   = 0;
        m_state[d] = 32'h0000_4000;
        m_count[d] = 0;
      end else if (gv[d]) begin
        pend[d][npend[d]] = ge[d];
        npend[d]++;
        if (npend[d] == 4) begin
          m_gate[d] = {pend[d][3], pend[d][2], pend[d][1], pend[d][0]};
          npend[d] = 0;
          busy_left[d] = lat[d] + 1;
        end
      end
    end
    #1;
  endtask

  task automatic push(input int d, input logic [15:0] e);
    gv[d] = 1'b1;
    ge[d] = e;
    step();
    gv[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sout[d] !== 32'h0000_4000) begin
        errs++;
        $display("FAIL reset_state[%0d]: got %h want 00004000", d, sout[d]);
      end
      checks++;
      if (rdy[d] !== 1'b1 || dn[d] !== 1'b0 || bsy[d] !== 1'b0) begin
        errs++;
        $display("FAIL reset_flags[%0d]: rdy/done/busy got %b%b%b want 100",
                 d, rdy[d], dn[d], bsy[d]);
      end
      checks++;
      if (gout[d] !== 64'h0) begin
        errs++;
        $display("FAIL reset_gate[%0d]: got %h want 0", d, gout[d]);
      end
    end
  endtask

  task automatic test_hadamard();
    logic [15:0] h [4];
    h = '{16'h2D00, 16'h2D00, 16'h2D00, 16'hAD00};
    for (int i = 0; i < 4; i++) push(0, h[i]);
    checks++;
    if (bsy[0] !== 1'b1 || dn[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      errs++;
      $display("FAIL had_settle: busy/done/rdy got %b%b%b want 100",
               bsy[0], dn[0], rdy[0]);
    end
    checks++;
    if (gout[0] !== 64'hAD00_2D00_2D00_2D00) begin
      errs++;
      $display("FAIL had_gate: got %h want AD002D002D002D00", gout[0]);
    end
    step();
    checks++;
    if (dn[0] !== 1'b1 || bsy[0] !== 1'b1) begin
      errs++;
      $display("FAIL had_done: done/busy got %b%b want 11", dn[0], bsy[0]);
    end
    checks++;
    if (sout[0] !== 32'h0000_4000) begin
      errs++;
      $display("FAIL had_hold: got %h want 00004000", sout[0]);
    end
    step();
    checks++;
    if (sout[0] !== 32'h2D00_2D00 || dn[0] !== 1'b0) begin
      errs++;
      $display("FAIL had_state: got %h done %b want 2D002D00 done 0",
               sout[0], dn[0]);
    end
  endtask

  task automatic test_pauli_x();
    logic [15:0] x [4];
    x = '{16'h0000, 16'h4000, 16'h4000, 16'h0000};
    ini[0] = 1'b1;
    step();
    ini[0] = 1'b0;
    for (int i = 0; i < 4; i++) push(0, x[i]);
    repeat (2) step();
    checks++;
    if (sout[0] !== 32'h4000_0000) begin
      errs++;
      $display("FAIL x_first: got %h want 40000000", sout[0]);
    end
    for (int i = 0; i < 4; i++) push(0, x[i]);
    repeat (2) step();
    checks++;
    if (sout[0] !== 32'h0000_4000) begin
      errs++;
      $display("FAIL x_second: got %h want 00004000", sout[0]);
    end
`ifdef STATE_SEQUENCER_GATE_COUNT_EN
    checks++;
    if (gcnt[0] !== 8'd2) begin
      errs++;
      $display("FAIL x_count: got %0d want 2", gcnt[0]);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [15:0] f [4];
    int nb;
    gv[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ge[1] = 16'($urandom);
      step();
    end
    nb = 0;
    for (int k = 0; k < 5; k++) begin
      if (bsy[1]) begin
        nb++;
        checks++;
        if (rdy[1] !== 1'b0 || gout[1] !== m_gate[1]) begin
          errs++;
          $display("FAIL bp_hold: rdy %b gate %h want 0 %h",
                   rdy[1], gout[1], m_gate[1]);
        end
      end
      if (k < 4) begin
        ge[1] = 16'($urandom);
        step();
      end
    end
    gv[1] = 1'b0;
    checks++;
    if (nb !== 4) begin
      errs++;
      $display("FAIL bp_busy_len: got %0d want 4", nb);
    end
    checks++;
    if (sout[1] !== m_state[1]) begin
      errs++;
      $display("FAIL bp_state: got %h want %h", sout[1], m_state[1]);
    end
    ini[1] = 1'b1;
    gv[1]  = 1'b1;
    ge[1]  = 16'h7F7F;
    #1;
    checks++;
    if (rdy[1] !== 1'b0) begin
      errs++;
      $display("FAIL conflict_rdy: got %b want 0", rdy[1]);
    end
    step();
    ini[1] = 1'b0;
    gv[1]  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f[i] = 16'($urandom);
      push(1, f[i]);
    end
    checks++;
    if (gout[1] !== {f[3], f[2], f[1], f[0]} || bsy[1] !== 1'b1) begin
      errs++;
      $display("FAIL conflict_fresh: got %h busy %b want %h busy 1",
               gout[1], bsy[1], {f[3], f[2], f[1], f[0]});
    end
    repeat (4) step();
    checks++;
    if (sout[1] !== m_state[1]) begin
      errs++;
      $display("FAIL conflict_state: got %h want %h", sout[1], m_state[1]);
    end
  endtask

  task automatic test_partial_init();
    logic [15:0] f [4];
    push(0, 16'($urandom));
    push(0, 16'($urandom));
    ini[0] = 1'b1;
    step();
    ini[0] = 1'b0;
    checks++;
    if (sout[0] !== 32'h0000_4000 || bsy[0] !== 1'b0) begin
      errs++;
      $display("FAIL pinit_state: got %h busy %b want 00004000 busy 0",
               sout[0], bsy[0]);
    end
    for (int i = 0; i < 4; i++) begin
      f[i] = {1'b0, 7'($urandom_range(0, 64)), 8'($urandom)};
      push(0, f[i]);
    end
    checks++;
    if (gout[0] !== {f[3], f[2], f[1], f[0]}) begin
      errs++;
      $display("FAIL pinit_gate: got %h want %h",
               gout[0], {f[3], f[2], f[1], f[0]});
    end
    repeat (2) step();
    checks++;
    if (sout[0] !== m_state[0]) begin
      errs++;
      $display("FAIL pinit_result: got %h want %h", sout[0], m_state[0]);
    end
  endtask

  task automatic test_reset_settle();
    for (int i = 0; i < 4; i++) push(1, 16'h4000);
    step();
    checks++;
    if (bsy[1] !== 1'b1) begin
      errs++;
      $display("FAIL rs_busy: got %b want 1", bsy[1]);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (dn[1] !== 1'b0 || bsy[1] !== 1'b0 || sout[1] !== 32'h0000_4000) begin
        errs++;
        $display("FAIL rs_after[%0d]: done %b busy %b state %h want 0 0 00004000",
                 k, dn[1], bsy[1], sout[1]);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int d = 0; d < 2; d++) begin
        ini[d] = ($urandom_range(0, 19) == 0);
        gv[d]  = ($urandom_range(0, 2) != 0);
        ge[d]  = 16'($urandom);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rdy[d] !== (busy_left[d] == 0 && !ini[d])) begin
          errs++;
          $display("FAIL rnd_rdy[%0d] c%0d: got %b", d, c, rdy[d]);
        end
      end
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (sout[d] !== m_state[d]) begin
          errs++;
          $display("FAIL rnd_state[%0d] c%0d: got %h want %h",
                   d, c, sout[d], m_state[d]);
        end
        checks++;
        if (bsy[d] !== (busy_left[d] > 0) || dn[d] !== (busy_left[d] == 1)) begin
          errs++;
          $display("FAIL rnd_flags[%0d] c%0d: busy %b done %b want %b %b",
                   d, c, bsy[d], dn[d], busy_left[d] > 0, busy_left[d] == 1);
        end
        if (busy_left[d] > 0) begin
          checks++;
          if (gout[d] !== m_gate[d]) begin
            errs++;
            $display("FAIL rnd_gate[%0d] c%0d: got %h want %h",
                     d, c, gout[d], m_gate[d]);
          end
        end
`ifdef STATE_SEQUENCER_GATE_COUNT_EN
        checks++;
        if (gcnt[d] !== 8'(m_count[d])) begin
          errs++;
          $display("FAIL rnd_count[%0d] c%0d: got %0d want %0d",
                   d, c, gcnt[d], m_count[d]);
        end
`endif
      end
    end
    for (int d = 0; d < 2; d++) begin
      gv[d]  = 1'b0;
      ini[d] = 1'b0;
    end
    repeat (6) step();
  endtask

  task automatic test_wrap();
    ini[0] = 1'b1;
    step();
    ini[0] = 1'b0;
    for (int g = 0; g < 256; g++) begin
      for (int i = 0; i < 4; i++) push(0, 16'($urandom));
      repeat (2) step();
`ifdef STATE_SEQUENCER_GATE_COUNT_EN
      if (g == 254) begin
        checks++;
        if (gcnt[0] !== 8'd255) begin
          errs++;
          $display("FAIL wrap_255: got %0d want 255", gcnt[0]);
        end
      end
`endif
    end
    checks++;
    if (sout[0] !== m_state[0]) begin
      errs++;
      $display("FAIL wrap_state: got %h want %h", sout[0], m_state[0]);
    end
`ifdef STATE_SEQUENCER_GATE_COUNT_EN
    checks++;
    if (gcnt[0] !== 8'd0) begin
      errs++;
      $display("FAIL wrap_count: got %0d want 0", gcnt[0]);
    end
`endif
  endtask

  initial begin
    lat[0] = 1;
    lat[1] = 3;
    for (int d = 0; d < 2; d++) begin
      gv[d]        = 1'b0;
      ge[d]        = '0;
      ini[d]       = 1'b0;
      busy_left[d] = 0;
      npend[d]     = 0;
      m_gate[d]    = '0;
      m_state[d]   = 32'h0000_4000;
      m_count[d]   = 0;
    end
    reset = 1'b0;
    #1;
    test_reset();
    test_hadamard();
    test_pauli_x();
    test_backpressure();
    test_partial_init();
    test_reset_settle();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
